// File: rtl/ram_be_clr.sv
// Single-port-per-direction RAM with per-lane byte enables, registered read data,
// and a sequential clear engine that zeroes the array after reset or on request.
module ram_be_clr #(
  parameter int unsigned Width       = 16,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned LaneWidth   = 8,
  parameter int unsigned ReadMode    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         we,
  input  logic [Width/LaneWidth-1:0]   be,
  input  logic [AddressSize-1:0]       waddr,
  input  logic [Width-1:0]             D,
  input  logic                         re,
  input  logic [AddressSize-1:0]       raddr,
  output logic [Width-1:0]             Q,
  output logic                         rvalid,
  output logic                         busy
);

  localparam int unsigned Lanes = Width / LaneWidth;
  localparam int unsigned Depth = 2 ** AddressSize;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [AddressSize-1:0] r_ptr;
  logic [AddressSize-1:0] w_ptr_nxt;
  logic [AddressSize-1:0] w_clr_addr;
  logic [Width-1:0]       r_mem [Depth];
  logic [Width-1:0]       r_q;
  logic [Width-1:0]       w_q_nxt;
  logic [Width-1:0]       w_merged;
  logic                   r_rvalid;
  logic                   w_rvalid_nxt;
  logic                   r_busy;
  logic                   w_clearing;
  logic                   w_user_we;

  // Word as it will look after the lane-masked write; also the ReadMode=1 bypass value.
  always_comb begin
    w_merged = r_mem[waddr];
    for (int unsigned k = 0; k < Lanes; k++) begin
      if (be[k]) begin
        w_merged[k*LaneWidth +: LaneWidth] = D[k*LaneWidth +: LaneWidth];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_clr_addr   = r_ptr;
    w_clearing   = 1'b0;
    w_user_we    = 1'b0;
    w_q_nxt      = r_q;
    w_rvalid_nxt = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clearing = 1'b1;
        w_q_nxt    = '0;
        // A clr request during a clear restarts the sweep at address 0 on this edge.
        if (clr) begin
          w_clr_addr = '0;
        end
        w_ptr_nxt = w_clr_addr + AddressSize'(1);
        if (w_clr_addr == {AddressSize{1'b1}}) begin
          w_state_nxt = S_READY;
        end
      end
      default: begin
        w_user_we = we;
        if (re) begin
          w_rvalid_nxt = 1'b1;
          if ((ReadMode != 0) && we && (waddr == raddr)) begin
            w_q_nxt = w_merged;
          end else begin
            w_q_nxt = r_mem[raddr];
          end
        end else if (clr) begin
          w_q_nxt = '0;
        end
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_CLEAR;
      r_ptr    <= '0;
      r_q      <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_q      <= w_q_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_busy   <= (w_state_nxt == S_CLEAR);
    end
  end

  // Array storage is not reset; the clear engine zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[waddr] <= w_merged;
    end
  end

  assign Q      = r_q;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_ram_be_clr.sv
// Scoreboard bench for ram_be_clr: ReadMode 0/1 instances on shared 16-bit stimulus,
// plus a 32-bit/64-deep instance exercised with random lane-masked traffic.
module tb_ram_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, we, re;
  logic [1:0]  be;
  logic [3:0]  waddr, raddr;
  logic [15:0] d;
  logic [15:0] q0, q1;
  logic        rv0, rv1, busy0, busy1;

  logic        c_clr, c_we, c_re;
  logic [3:0]  c_be;
  logic [5:0]  c_waddr, c_raddr;
  logic [31:0] c_d, q32;
  logic        rv32, busy32;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_mem [16];
  logic [31:0] m32 [64];
  int          m_clr_left;
  logic [15:0] m_q0, m_q1;
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  logic [31:0] exp32 [$];

  always #5 clk = ~clk;

  ram_be_clr #(.Width(16), .AddressSize(4), .LaneWidth(8), .ReadMode(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .waddr(waddr), .D(d),
    .re(re), .raddr(raddr), .Q(q0), .rvalid(rv0), .busy(busy0));

  ram_be_clr #(.Width(16), .AddressSize(4), .LaneWidth(8), .ReadMode(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .waddr(waddr), .D(d),
    .re(re), .raddr(raddr), .Q(q1), .rvalid(rv1), .busy(busy1));

  ram_be_clr #(.Width(32), .AddressSize(6), .LaneWidth(8), .ReadMode(0)) u_dut32 (
    .clk(clk), .rst(rst), .clr(c_clr), .we(c_we), .be(c_be), .waddr(c_waddr), .D(c_d),
    .re(c_re), .raddr(c_raddr), .Q(q32), .rvalid(rv32), .busy(busy32));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_clr_left = 16;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_q0 = '0;
    m_q1 = '0;
  endtask

  task automatic drive_idle();
    clr = 0; we = 0; re = 0; be = '0; waddr = '0; raddr = '0; d = '0;
  endtask

  // One clock of 16-bit stimulus; the model predicts both ReadMode variants.
  task automatic op(input logic i_we, input logic [1:0] i_be, input logic [3:0] i_wa,
                    input logic [15:0] i_d, input logic i_re, input logic [3:0] i_ra,
                    input logic i_clr);
    logic [15:0] merged;
    logic        rd;
    clr = i_clr; we = i_we; be = i_be; waddr = i_wa; d = i_d; re = i_re; raddr = i_ra;
    rd = 1'b0;
    if (m_clr_left == 0) begin
      merged = m_mem[i_wa];
      for (int k = 0; k < 2; k++) if (i_be[k]) merged[k*8 +: 8] = i_d[k*8 +: 8];
      if (i_re) begin
        rd   = 1'b1;
        m_q0 = m_mem[i_ra];
        m_q1 = (i_we && i_wa == i_ra) ? merged : m_mem[i_ra];
        exp0.push_back(m_q0);
        exp1.push_back(m_q1);
      end else if (i_clr) begin
        m_q0 = '0;
        m_q1 = '0;
      end
      if (i_we) m_mem[i_wa] = merged;
      if (i_clr) begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_clr_left = 16;
      end
    end else begin
      m_q0 = '0;
      m_q1 = '0;
      if (i_clr) m_clr_left = 15;
      else m_clr_left--;
    end
    @(posedge clk);
    #1;
    check("busy0", 32'(busy0), 32'(m_clr_left > 0));
    check("busy1", 32'(busy1), 32'(m_clr_left > 0));
    check("rvalid0", 32'(rv0), 32'(rd));
    check("q0_state", 32'(q0), 32'(m_q0));
    check("q1_state", 32'(q1), 32'(m_q1));
    drive_idle();
  endtask

  task automatic idle();
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd16(input int a);
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(a), 1'b0);
  endtask

  task automatic wr16(input int a, input logic [1:0] b, input logic [15:0] v);
    op(1'b1, b, 4'(a), v, 1'b0, 4'd0, 1'b0);
  endtask

  // One clock of 32-bit traffic against a ReadMode=0 reference.
  task automatic op32(input logic i_we, input logic [3:0] i_be, input logic [5:0] i_wa,
                      input logic [31:0] i_d, input logic i_re, input logic [5:0] i_ra);
    c_we = i_we; c_be = i_be; c_waddr = i_wa; c_d = i_d; c_re = i_re; c_raddr = i_ra;
    if (i_re) exp32.push_back(m32[i_ra]);
    if (i_we) begin
      for (int k = 0; k < 4; k++) if (i_be[k]) m32[i_wa][k*8 +: 8] = i_d[k*8 +: 8];
    end
    @(posedge clk);
    #1;
    check("rvalid32", 32'(rv32), 32'(i_re));
    c_we = 0; c_re = 0; c_be = '0;
  endtask

  // Scoreboard monitor: each presented read result is matched against the queue head.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst) begin
      if (rv0) begin
        if (exp0.size() == 0) check("rv0_unexpected", 32'(rv0), 32'd0);
        else begin e = 32'(exp0.pop_front()); check("sb_q0", 32'(q0), e); end
      end
      if (rv1) begin
        if (exp1.size() == 0) check("rv1_unexpected", 32'(rv1), 32'd0);
        else begin e = 32'(exp1.pop_front()); check("sb_q1", 32'(q1), e); end
      end
      if (rv32) begin
        if (exp32.size() == 0) check("rv32_unexpected", 32'(rv32), 32'd0);
        else begin e = exp32.pop_front(); check("sb_q32", q32, e); end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    c_clr = 0; c_we = 0; c_re = 0; c_be = '0; c_waddr = '0; c_raddr = '0; c_d = '0;
    model_reset();
    #3;
    check("reset_busy", 32'(busy0), 32'd1);
    check("reset_q", 32'(q0), 32'd0);
    check("reset_rvalid", 32'(rv0), 32'd0);
    check("reset_busy32", 32'(busy32), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Initial clear: exactly 16 busy edges, then every word reads zero.
    for (int i = 0; i < 16; i++) idle();
    for (int a = 0; a < 16; a++) rd16(a);
    idle();

    // Lane-masked update.
    wr16(3, 2'b11, 16'hA5C3);
    wr16(3, 2'b01, 16'h1177);
    rd16(3);
    check("lane_merge", 32'(q0), 32'h0000A577);

    // Same-address read during write: old data vs merged data.
    wr16(5, 2'b11, 16'h1234);
    op(1'b1, 2'b10, 4'd5, 16'hBEEF, 1'b1, 4'd5, 1'b0);
    check("rdw_old", 32'(q0), 32'h00001234);
    check("rdw_new", 32'(q1), 32'h0000BE34);
    rd16(5);
    check("rdw_after", 32'(q0), 32'h0000BE34);

    // Different-address read/write and an all-lanes-disabled write.
    op(1'b1, 2'b11, 4'd6, 16'hCAFE, 1'b1, 4'd3, 1'b0);
    check("rw_diff", 32'(q0), 32'h0000A577);
    wr16(6, 2'b00, 16'hFFFF);
    rd16(6);
    check("be_zero", 32'(q0), 32'h0000CAFE);
    idle();
    check("q_hold", 32'(q0), 32'h0000CAFE);

    // Fill, then a one-edge clr; traffic while busy must be ignored.
    for (int a = 0; a < 16; a++) wr16(a, 2'b11, 16'(a * 16'h0101));
    rd16(9);
    rd16(15);
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 15; i++) op(1'b1, 2'b11, 4'(i), 16'hFFFF, 1'b1, 4'(i), 1'b0);
    idle();
    for (int a = 0; a < 16; a++) rd16(a);

    // clr during a clear restarts the sweep.
    wr16(1, 2'b11, 16'h5A5A);
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 40 && m_clr_left > 0; i++) idle();
    rd16(1);

    // Async reset mid-operation: Q drops without a clock edge.
    wr16(2, 2'b11, 16'h7E81);
    rd16(2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_op_q", 32'(q0), 32'd0);
    check("arst_op_busy", 32'(busy0), 32'd1);
    check("arst_op_rvalid", 32'(rv0), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) idle();
    rd16(2);

    // Async reset mid-clear at ptr=7.
    op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_clr_q", 32'(q0), 32'd0);
    check("arst_clr_busy", 32'(busy0), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) idle();
    rd16(0);
    rd16(15);
    idle();

    // Wide configuration: wait for its own 64-edge clear, then random traffic.
    for (int i = 0; i < 200 && busy32; i++) @(posedge clk);
    #1;
    check("busy32_done", 32'(busy32), 32'd0);
    for (int i = 0; i < 64; i++) m32[i] = '0;
    for (int i = 0; i < 1000; i++) begin
      op32(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
           $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end
    for (int a = 0; a < 64; a++) op32(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(a));
    op32(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
    @(posedge clk);
    #1;

    check("sb0_drain", 32'(exp0.size()), 32'd0);
    check("sb1_drain", 32'(exp1.size()), 32'd0);
    check("sb32_drain", 32'(exp32.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_be_clr.md
RAM_BE_CLR -- requirements
Module: ram_be_clr

Interface
REQ-001 The block SHALL have parameter Width, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter AddressSize, default 4, meaning address width; depth is 2**AddressSize words.
REQ-003 The block SHALL have parameter LaneWidth, default 8, meaning bits per write-enable lane; Width SHALL be an integer multiple of LaneWidth.
REQ-004 The block SHALL have parameter ReadMode, default 0, meaning same-address read-during-write result: 0 = old data, 1 = new (merged) data.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-007 The block SHALL have port clr, input, 1 bit, synchronous request to zero the whole array.
REQ-008 The block SHALL have port we, input, 1 bit, write enable.
REQ-009 The block SHALL have port be, input, Width/LaneWidth bits, per-lane write enable; bit k covers D[k*LaneWidth +: LaneWidth].
REQ-010 The block SHALL have port waddr, input, AddressSize bits, write address.
REQ-011 The block SHALL have port D, input, Width bits, write data.
REQ-012 The block SHALL have port re, input, 1 bit, read enable.
REQ-013 The block SHALL have port raddr, input, AddressSize bits, read address.
REQ-014 The block SHALL have port Q, output, Width bits, registered read data.
REQ-015 The block SHALL have port rvalid, output, 1 bit, Q updated by a read at the last edge.
REQ-016 The block SHALL have port busy, output, 1 bit, clear sequence in progress.

Function
REQ-017 The control FSM SHALL have two states: CLEAR and READY, plus a clear pointer of AddressSize bits.
REQ-018 In CLEAR, each edge SHALL write all-zero to mem[ptr] and increment ptr; the edge that writes address 2**AddressSize-1 SHALL move the FSM to READY, so a full clear takes exactly 2**AddressSize edges.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY; Q SHALL be held at 0 and rvalid at 0 while in CLEAR.
REQ-020 In CLEAR, we, be, re and user addresses SHALL be ignored (no user write, no read).
REQ-021 clr=1 at an edge in READY SHALL enter CLEAR with ptr=0; clr=1 at an edge in CLEAR SHALL restart ptr at 0 (that edge clears address 0).
REQ-022 In READY with we=1, each lane k with be[k]=1 SHALL be written from D; lanes with be[k]=0 SHALL keep their value; we=1 with be all-zero SHALL change nothing.
REQ-023 In READY with re=1, Q SHALL equal mem[raddr] after that edge (1-cycle latency) and rvalid SHALL be 1 for that cycle.
REQ-024 In READY with re=0, Q SHALL hold its previous value and rvalid SHALL be 0.
REQ-025 Read and write at the same edge to the same address: ReadMode=0 SHALL return the pre-write word; ReadMode=1 SHALL return the word with enabled lanes from D and other lanes old.
REQ-026 Read and write at the same edge to different addresses SHALL both complete normally.
REQ-027 clr=1 with we=1 and/or re=1 at the same READY edge: the user write and read SHALL occur at that edge, then CLEAR begins.

Reset
REQ-028 rst=1 SHALL immediately (without clk) force FSM=CLEAR, ptr=0, Q=0, rvalid=0, busy=1.
REQ-029 After rst falls, the clear sequence of REQ-018 SHALL run, so busy stays 1 for exactly 2**AddressSize rising edges.
REQ-030 rst asserted mid-clear or mid-operation SHALL restart the clear from address 0; array contents after the completed clear SHALL be all zero.

Verification
REQ-031 Reset then release: busy=1 for exactly 16 edges, then 0; reading all 16 addresses returns 16'h0000 with rvalid=1 each cycle.
REQ-032 Write 16'hA5C3 be=2'b11 to addr 3, then be=2'b01 D=16'h1177 to addr 3; read addr 3 -> Q=16'hA577.
REQ-033 ReadMode=0: mem[5]=16'h1234; same edge write 16'hBEEF be=2'b10 and read addr 5 -> Q=16'h1234; next read -> 16'hBE34. ReadMode=1: same stimulus -> first Q=16'hBE34.
REQ-034 Fill all addresses with address*16'h0101, pulse clr for one edge: busy=1 for 16 edges, writes/reads during busy ignored (rvalid=0, Q=0); afterwards every address reads 16'h0000.
REQ-035 Assert rst asynchronously between clk edges mid-clear (ptr=7): Q=0, busy=1 immediately; clear restarts and completes 16 edges after release.
REQ-036 Parameter sweep Width=32, LaneWidth=8, AddressSize=6: random lane-masked writes vs. a reference model, 0 mismatches over 1000 operations.
